// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions used by the shift execution unit.
//   - R-type funct codes for the six shift instructions
//   - shift_state_t : control states of the serial shifter
package mips_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational decode of an R-type funct code into shift controls.
//   funct    : R-type function code
//   is_left  : shift toward the MSB
//   is_arith : right shift replicates the sign bit
//   is_var   : amount comes from rs_val instead of shamt
//   legal    : funct is one of the six shift instructions
module shift_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic       is_left,
  output logic       is_arith,
  output logic       is_var,
  output logic       legal
);

  // Within the shift group, bit 2 selects the variable form and bits [1:0]
  // select the kind: 00 left, 10 logical right, 11 arithmetic right.
  always_comb begin
    is_left  = (funct[1:0] == 2'b00);
    is_arith = (funct[1:0] == 2'b11);
    is_var   = funct[2];
    legal    = 1'b0;
    case (funct)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shift execution unit: shifts rt_val by one bit per clock.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : request, sampled only while idle
//   funct      : R-type funct code (SLL/SRL/SRA/SLLV/SRLV/SRAV)
//   shamt      : immediate amount for the fixed-amount forms
//   rs_val     : low SHAMT_W bits give the amount for the variable forms
//   rt_val     : value to shift
//   busy       : high while an operation is in progress, including done cycle
//   done       : one-cycle pulse, result valid
//   illegal    : pulses with done when funct is not a shift
//   result     : shifted value, held until the next accepted start
module serial_shifter
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [WIDTH-1:0]   result
);

  shift_state_t       state, next_state;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   work;
  logic               dir_left;
  logic               dir_arith;

  logic               dec_left, dec_arith, dec_var, dec_legal;
  logic [SHAMT_W-1:0] amount;
  logic               accept;
  logic               last_step;

  logic               unused_rs_hi;
  assign unused_rs_hi = ^rs_val[WIDTH-1:SHAMT_W];

  // One shift step in the latched direction.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w,
                                                  input logic left,
                                                  input logic arith);
    logic signed [WIDTH-1:0] ws;
    ws = w;
    if (left)
      return {w[WIDTH-2:0], 1'b0};
    else if (arith)
      return ws >>> 1;
    else
      return {1'b0, w[WIDTH-1:1]};
  endfunction

  shift_op_decode u_decode (
    .funct    (funct),
    .is_left  (dec_left),
    .is_arith (dec_arith),
    .is_var   (dec_var),
    .legal    (dec_legal)
  );

  assign amount    = dec_var ? rs_val[SHAMT_W-1:0] : shamt;
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == SHIFT) && (cnt == SHAMT_W'(1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!dec_legal || (amount == '0))
            next_state = DONE;
          else
            next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == SHAMT_W'(1))
          next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
    end else begin
      state   <= next_state;
      busy    <= (next_state != IDLE);
      done    <= (next_state == DONE);
      illegal <= accept && !dec_legal;
      if (accept) begin
        cnt <= amount;
        // Zero-amount and illegal requests complete immediately with rt_val.
        if (!dec_legal || (amount == '0))
          result <= rt_val;
      end else if (state == SHIFT) begin
        cnt <= cnt - SHAMT_W'(1);
        if (last_step)
          result <= shift_step(work, dir_left, dir_arith);
      end
    end
  end

  // Working datapath, no reset needed: always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      work      <= rt_val;
      dir_left  <= dec_left;
      dir_arith <= dec_arith;
    end else if (state == SHIFT) begin
      work <= shift_step(work, dir_left, dir_arith);
    end
  end

endmodule
